// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, default bit period and frame width.
// Macro ODBIORNIK_MAJORITY_EN adds the 2-of-3 vote helper.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 10417;
    localparam int unsigned FRAME_W          = 8;
    localparam int unsigned CNT_W            = 32;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        s_SPOCZYNEK   = 3'd0,
        s_START       = 3'd1,
        s_DATA        = 3'd2,
        s_STOP        = 3'd3,
        s_CZYSZCZENIE = 3'd4,
        s_CZEKAJ      = 3'd5
    } uart_state_t;

`ifdef ODBIORNIK_MAJORITY_EN
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
`endif

endpackage

// File: rtl/synchronizator.sv
// Two-flop synchronizer for an asynchronous single-bit input; resets to INIT.
module synchronizator #(
    parameter logic INIT = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta <= INIT;
            q    <= INIT;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/odbiornik.sv
// 8N1 UART receiver with mid-bit sampling, framing-error detection and break wait.
// Macro ODBIORNIK_MAJORITY_EN selects 2-of-3 majority sampling around each mid-bit point.
module odbiornik
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               RXD_i,
    output logic [FRAME_W-1:0] rxDATA,
    output logic               RX_END,
    output logic               RX_ERR,
    output logic               RX_BUSY
);

    localparam int unsigned IDX_W   = $clog2(FRAME_W);
    localparam cnt_t        START_T = cnt_t'(HALF_BIT - 1);
    localparam cnt_t        BIT_T   = cnt_t'(CLKS_PER_BIT - 1);
`ifdef ODBIORNIK_MAJORITY_EN
    // Decision lands one cycle past target; reloading 1 keeps the bit grid from drifting.
    localparam cnt_t        RELOAD  = cnt_t'(1);
`else
    localparam cnt_t        RELOAD  = cnt_t'(0);
`endif

    uart_state_t        state;
    cnt_t               cnt;
    logic [IDX_W-1:0]   bit_idx;
    logic [FRAME_W-1:0] shift;
    logic               rx_s;
    cnt_t               tgt;
    logic               sample_now;
    logic               sample_bit;

    synchronizator #(.INIT(1'b1)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d     (RXD_i),
        .q     (rx_s)
    );

    assign tgt = (state == s_START) ? START_T : BIT_T;

`ifdef ODBIORNIK_MAJORITY_EN
    logic [1:0] votes;

    // Capture the two early votes; the third is the live rx_s at decision time.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            votes <= 2'b11;
        end else begin
            if (cnt == tgt - cnt_t'(1)) votes[1] <= rx_s;
            if (cnt == tgt)             votes[0] <= rx_s;
        end
    end

    always_comb begin
        sample_now = 1'b0;
        sample_bit = 1'b1;
        sample_now = (cnt == tgt + cnt_t'(1));
        sample_bit = majority3(votes[1], votes[0], rx_s);
    end
`else
    always_comb begin
        sample_now = 1'b0;
        sample_bit = 1'b1;
        sample_now = (cnt == tgt);
        sample_bit = rx_s;
    end
`endif

    // Receive FSM with registered data and status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= s_SPOCZYNEK;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            rxDATA  <= '0;
            RX_END  <= 1'b0;
            RX_ERR  <= 1'b0;
            RX_BUSY <= 1'b0;
        end else begin
            RX_END <= 1'b0;
            RX_ERR <= 1'b0;
            case (state)
                s_SPOCZYNEK: begin
                    RX_BUSY <= 1'b0;
                    if (!rx_s) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= s_START;
                        RX_BUSY <= 1'b1;
                    end
                end
                s_START: begin
                    if (sample_now) begin
                        if (!sample_bit) begin
                            cnt   <= RELOAD;
                            state <= s_DATA;
                        end else begin
                            state   <= s_SPOCZYNEK;
                            RX_BUSY <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                s_DATA: begin
                    if (sample_now) begin
                        shift[bit_idx] <= sample_bit;
                        cnt            <= RELOAD;
                        bit_idx        <= bit_idx + IDX_W'(1);
                        if (bit_idx == IDX_W'(FRAME_W - 1)) state <= s_STOP;
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                s_STOP: begin
                    if (sample_now) begin
                        cnt <= '0;
                        if (sample_bit) begin
                            rxDATA <= shift;
                            RX_END <= 1'b1;
                            state  <= s_CZYSZCZENIE;
                        end else begin
                            RX_ERR <= 1'b1;
                            state  <= s_CZEKAJ;
                        end
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                s_CZYSZCZENIE: begin
                    state   <= s_SPOCZYNEK;
                    RX_BUSY <= 1'b0;
                end
                s_CZEKAJ: begin
                    // Hold off until the line returns high so a break is not read as a start.
                    if (rx_s) begin
                        state   <= s_SPOCZYNEK;
                        RX_BUSY <= 1'b0;
                    end
                end
                default: begin
                    state   <= s_SPOCZYNEK;
                    RX_BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule
